// File: rtl/mdu_ctrl_if.sv
// HI/LO unit bus: E-stage request, operands and flush toward the MDU;
// busy flag, move-from read data and architectural HI/LO back to the pipeline.
interface mdu_ctrl_if;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        HILObusy;
  logic [31:0] MDOut;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDOp, A, B, Req,
                  input  HILObusy, MDOut, HI, LO);
  modport slave  (input  Start, MDOp, A, B, Req,
                  output HILObusy, MDOut, HI, LO);
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle HI/LO controller: result computed at launch, held in pHI/pLO, committed after N busy cycles.
// Define MDU_DIV_ZERO_KEEP_EN to leave HI/LO untouched on divide by zero (default: LO=all ones, HI=A).
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  mdu_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;

  logic               is_mul, is_div, accept, launch;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s, b_s, quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;
  logic        [31:0] res_hi, res_lo;

  always_comb begin
    is_mul = (bus.MDOp == 4'd1) || (bus.MDOp == 4'd2);
    is_div = (bus.MDOp == 4'd3) || (bus.MDOp == 4'd4);
    accept = (state_q == IDLE) && bus.Start && !bus.Req;
    launch = accept && (is_mul || is_div);
  end

  // Most-negative / -1 is forced explicitly so the wrap result never depends on the tool.
  always_comb begin
    a_s    = bus.A;
    b_s    = bus.B;
    prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (bus.B != 32'd0) begin
      if ((bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF)) begin
        quot_s = a_s;
        rem_s  = '0;
      end else begin
        quot_s = a_s / b_s;
        rem_s  = a_s % b_s;
      end
      quot_u = bus.A / bus.B;
      rem_u  = bus.A % bus.B;
    end

    res_hi = '0;
    res_lo = '0;
    case (bus.MDOp)
      4'd1:    begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      4'd2:    begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      4'd3:    begin res_hi = rem_s;         res_lo = quot_s;       end
      4'd4:    begin res_hi = rem_u;         res_lo = quot_u;       end
      default: begin res_hi = '0;            res_lo = '0;           end
    endcase

    if (is_div && (bus.B == 32'd0)) begin
`ifdef MDU_DIV_ZERO_KEEP_EN
      res_hi = hi_q;
      res_lo = lo_q;
`else
      res_hi = bus.A;
      res_lo = 32'hFFFF_FFFF;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = BUSY;
          cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          phi_d   = res_hi;
          plo_d   = res_lo;
        end else if (accept && (bus.MDOp == 4'd5)) begin
          hi_d = bus.A;
        end else if (accept && (bus.MDOp == 4'd6)) begin
          lo_d = bus.A;
        end
      end
      BUSY: begin
        // Inputs are ignored here; the only way out is the count reaching 1 (or reset).
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = phi_q;
          lo_d    = plo_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign bus.HILObusy = (state_q == BUSY) || launch;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.MDOut    = (bus.MDOp == 4'd7) ? hi_q :
                        (bus.MDOp == 4'd8) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: each launch pushes its busy length and HI/LO result;
// a monitor pops on every busy-window end and compares.
module tb_mdu_ctrl;

  localparam int SEL_MD   = 0;
  localparam int SEL_HI   = 1;
  localparam int SEL_LO   = 2;
  localparam int SEL_BUSY = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    int          busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic record(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b, input logic rq);
    @(posedge clk);
    #1;
    bus.Start = st;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    bus.Req   = rq;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic expectOp(input string name, input int busy, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.name = name;
    e.busy = busy;
    e.hi   = hi;
    e.lo   = lo;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    logic [31:0] act;
    @(negedge clk);
    case (sel)
      SEL_MD:  act = bus.MDOut;
      SEL_HI:  act = bus.HI;
      SEL_LO:  act = bus.LO;
      default: act = {31'd0, bus.HILObusy};
    endcase
    record(name, act, exp);
  endtask

  // Monitor: measures each busy window and checks HI/LO on the first cycle after it.
  initial begin : monitor
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (bus.HILObusy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (sb.size() == 0) begin
          record("unexpected_busy_window", 32'(run), 32'd0);
        end else begin
          e = sb.pop_front();
          record({e.name, "_busy_len"}, 32'(run), 32'(e.busy));
          record({e.name, "_hi"}, bus.HI, e.hi);
          record({e.name, "_lo"}, bus.LO, e.lo);
        end
        run = 0;
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.MDOp  = 4'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.Req   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset_busy", SEL_BUSY, 32'd0);
    checkOutput("reset_hi", SEL_HI, 32'd0);
    checkOutput("reset_lo", SEL_LO, 32'd0);
    applyStimulus(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
    checkOutput("reset_mdout", SEL_MD, 32'd0);

    // mult -2 * 3
    expectOp("mult_neg", 6, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    applyStimulus(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    checkOutput("mult_launch_busy", SEL_BUSY, 32'd1);
    idleCycles(7);
    applyStimulus(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
    checkOutput("mult_mfhi", SEL_MD, 32'hFFFF_FFFF);

    // divu 7 / 2
    expectOp("divu", 11, 32'd1, 32'd3);
    applyStimulus(1'b1, 4'd4, 32'd7, 32'd2, 1'b0);
    idleCycles(12);
    applyStimulus(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
    checkOutput("divu_mfhi", SEL_MD, 32'd1);
    applyStimulus(1'b0, 4'd8, 32'd0, 32'd0, 1'b0);
    checkOutput("divu_mflo", SEL_MD, 32'd3);

    // div -7 / 2, with a flushed relaunch attempt during BUSY
    expectOp("div_neg", 11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus(1'b1, 4'd1, 32'd100, 32'd100, 1'b1);
    idleCycles(12);

    // most-negative / -1
    expectOp("div_ovf", 11, 32'd0, 32'h8000_0000);
    applyStimulus(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idleCycles(12);

    // multu all-ones squared
    expectOp("multu_max", 6, 32'hFFFF_FFFE, 32'h0000_0001);
    applyStimulus(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idleCycles(7);

    // flushed launch, no-op op, flushed mthi
    applyStimulus(1'b1, 4'd1, 32'd5, 32'd5, 1'b1);
    checkOutput("req_launch_busy", SEL_BUSY, 32'd0);
    idleCycles(2);
    checkOutput("req_launch_busy_after", SEL_BUSY, 32'd0);
    checkOutput("req_launch_hi", SEL_HI, 32'hFFFF_FFFE);
    checkOutput("req_launch_lo", SEL_LO, 32'h0000_0001);
    applyStimulus(1'b1, 4'd9, 32'd77, 32'd77, 1'b0);
    checkOutput("noop_busy", SEL_BUSY, 32'd0);
    idleCycles(1);
    checkOutput("noop_lo", SEL_LO, 32'h0000_0001);
    applyStimulus(1'b1, 4'd5, 32'h0000_DEAD, 32'd0, 1'b1);
    idleCycles(1);
    checkOutput("req_mthi_hi", SEL_HI, 32'hFFFF_FFFE);

    // mthi, then mtlo during a mult's BUSY
    applyStimulus(1'b1, 4'd5, 32'h0000_1234, 32'd0, 1'b0);
    idleCycles(1);
    checkOutput("mthi_hi", SEL_HI, 32'h0000_1234);
    expectOp("mult_small", 6, 32'd0, 32'd6);
    applyStimulus(1'b1, 4'd1, 32'd2, 32'd3, 1'b0);
    applyStimulus(1'b1, 4'd6, 32'd5, 32'd0, 1'b0);
    idleCycles(1);
    checkOutput("busy_mtlo_ignored", SEL_LO, 32'h0000_0001);
    idleCycles(6);

    // divu by zero, reset in the 4th BUSY cycle
    expectOp("divu_zero_reset", 5, 32'd0, 32'd0);
    applyStimulus(1'b1, 4'd4, 32'd9, 32'd0, 1'b0);
    idleCycles(3);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.MDOp  = 4'd0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.MDOp = 4'd7;
    checkOutput("post_reset_busy", SEL_BUSY, 32'd0);
    checkOutput("post_reset_mfhi", SEL_MD, 32'd0);
    applyStimulus(1'b0, 4'd8, 32'd0, 32'd0, 1'b0);
    checkOutput("post_reset_mflo", SEL_MD, 32'd0);
    idleCycles(13);
    checkOutput("post_reset_no_commit_lo", SEL_LO, 32'd0);

    // divu by zero to completion
    applyStimulus(1'b1, 4'd5, 32'hAAAA_5555, 32'd0, 1'b0);
    applyStimulus(1'b1, 4'd6, 32'h0000_BEEF, 32'd0, 1'b0);
    idleCycles(1);
`ifdef MDU_DIV_ZERO_KEEP_EN
    expectOp("divu_zero", 11, 32'hAAAA_5555, 32'h0000_BEEF);
`else
    expectOp("divu_zero", 11, 32'd9, 32'hFFFF_FFFF);
`endif
    applyStimulus(1'b1, 4'd4, 32'd9, 32'd0, 1'b0);
    idleCycles(13);

    checkOutput("final_busy", SEL_BUSY, 32'd0);
    record("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The module SHALL have parameter MULT_CYCLES, default 5: busy duration of mult/multu, in cycles.
REQ-002 The module SHALL have parameter DIV_CYCLES, default 10: busy duration of div/divu, in cycles.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port Start, input, 1 bit: the E-stage instruction is a HI/LO operation.
REQ-006 The module SHALL have port MDOp, input, 4 bits: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; all other values are no-op.
REQ-007 The module SHALL have port A, input, 32 bits: rs operand.
REQ-008 The module SHALL have port B, input, 32 bits: rt operand.
REQ-009 The module SHALL have port Req, input, 1 bit: exception/interrupt flush; suppresses any new effect in the same cycle.
REQ-010 The module SHALL have port HILObusy, output, 1 bit: HI/LO unavailable; feeds the stall unit.
REQ-011 The module SHALL have port MDOut, output, 32 bits: mfhi/mflo read data.
REQ-012 The module SHALL have port HI, output, 32 bits: architectural HI register.
REQ-013 The module SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-015 Launch condition SHALL be: IDLE & Start & !Req & MDOp in {1,2,3,4}.
REQ-016 On launch, the block SHALL latch the result into shadow registers pHI/pLO, go to BUSY, and load the counter with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
REQ-017 mult SHALL produce the signed 64-bit A*B and multu the unsigned 64-bit A*B; result {HI,LO} = 64-bit product.
REQ-018 div SHALL produce signed LO=A/B, HI=A%B, truncating toward zero, with remainder sign = dividend sign; divu SHALL produce the unsigned equivalents.
REQ-019 div 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-020 In BUSY the counter SHALL decrement once per cycle; in the cycle it equals 1, the block SHALL commit HI<=pHI, LO<=pLO and go to IDLE.
REQ-021 New HI/LO SHALL be visible on the first IDLE cycle.
REQ-022 HILObusy SHALL equal (state==BUSY) | launch condition (combinational), so it is high in the launch cycle plus exactly N BUSY cycles.
REQ-023 The sequence launch, N BUSY cycles, commit SHALL be followed by HILObusy=0 on the commit+1 cycle.
REQ-024 mthi (MDOp=5) with Start & !Req & IDLE SHALL write HI<=A at the next edge; mtlo (MDOp=6) SHALL write LO<=A under the same condition.
REQ-025 MDOut SHALL be combinational: HI when MDOp=7, LO when MDOp=8, otherwise 0.
REQ-026 MDOut SHALL always reflect the committed registers, never pHI/pLO.
REQ-027 A Start with any op while BUSY SHALL be ignored (no relaunch, no mt write, counter unaffected); the stall unit guarantees this does not occur, and the bench checks robustness.
REQ-028 Req while BUSY SHALL NOT cancel the in-flight operation, which commits normally.
REQ-029 Req in the launch cycle SHALL suppress the launch: state stays IDLE and HILObusy=0.
REQ-030 Req asserted together with mthi/mtlo SHALL suppress the write.
REQ-031 Start with a no-op MDOp SHALL have no effect.
REQ-032 MULT_CYCLES and DIV_CYCLES SHALL each be >= 1.
REQ-033 Counter width SHALL be sized to max(MULT_CYCLES, DIV_CYCLES).

Reset
REQ-034 Synchronous reset SHALL set state=IDLE and counter=0.
REQ-035 Synchronous reset SHALL set HI=0, LO=0, pHI=0 and pLO=0.
REQ-036 Reset asserted mid-operation SHALL discard the pending result with no commit; HILObusy=0 and MDOut=0 (for MDOp 7/8) in the cycle after reset.
REQ-037 Reset SHALL take priority over Start, Req and commit.

Configuration
REQ-038 Macro MDU_DIV_ZERO_KEEP_EN SHALL select divide-by-zero behaviour.
REQ-039 With MDU_DIV_ZERO_KEEP_EN defined: div/divu with B==0 still runs DIV_CYCLES busy, and the commit leaves HI/LO unchanged.
REQ-040 Without MDU_DIV_ZERO_KEEP_EN: div/divu with B==0 commits LO=32'hFFFFFFFF and HI=A.

Verification
REQ-041 The bench SHALL cover: reset; mult A=32'hFFFFFFFE (-2), B=3; HILObusy high 6 cycles (launch+5) -> then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-042 The bench SHALL cover: divu A=7, B=2 -> HILObusy high 11 cycles; HI=1, LO=3; MDOp=7 gives MDOut=1, MDOp=8 gives MDOut=3.
REQ-043 The bench SHALL cover: div A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-044 The bench SHALL cover: Start mult with Req=1 -> HILObusy=0 the whole time, HI/LO unchanged.
REQ-045 The bench SHALL cover: mthi A=32'h1234 -> HI=32'h1234 next cycle; during the BUSY of a following mult, mtlo A=5 -> ignored.
REQ-046 The bench SHALL cover: divu B=0, A=9, then reset at BUSY cycle 4 -> HILObusy=0, HI=LO=0, no commit; repeat without reset -> macro-dependent result per REQ-039/REQ-040.
